pipeline_mem_arbiter: RTL and testbench

- Shares one single-ported memory between the IF stage (instruction reads) and the MEM stage (lw/sw).
- MEM-side requests come straight from the decoded MemRead/MemWrite control bits.
- Sequences each access through a request/acknowledge handshake with variable latency.
- Drives stall outputs to the pipeline while an access is pending; round-robin tie-break prevents IF starvation.

---
 rtl/pipeline_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter.sv
// rtl/pipeline_mem_arbiter.sv - IF/MEM arbiter for one single-ported memory, round-robin on ties.
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module pipeline_mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              arb_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

    state_t              state, state_n;
    logic                last_dm, last_dm_n;
    logic                mem_req_n, mem_we_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [DATA_W-1:0]   if_rdata_n, dm_rdata_n;
    logic                if_valid_n, dm_valid_n;
    logic                dm_any, grant_dm, expired, finish;
    logic [DATA_W-1:0]   rdata_sel;

    assign dm_any   = dm_read | dm_write;
    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_any & ~dm_valid;
    // On a tie the side that was not served last wins; last_dm=0 after reset lets DM win first.
    assign grant_dm = dm_any & (~if_req | ~last_dm);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             err_q, err_n;

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));
    assign arb_err = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            err_q <= err_n;
        end
    end
`else
    assign expired = 1'b0;
    assign arb_err = 1'b0;
`endif

    // A timed-out access completes like a normal one but returns zero data.
    assign finish    = mem_ack | expired;
    assign rdata_sel = mem_ack ? mem_rdata : '0;

    always_comb begin
        state_n     = state;
        last_dm_n   = last_dm;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        if_valid_n  = 1'b0;
        dm_valid_n  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n       = cnt;
        err_n       = err_q;
`endif
        case (state)
            IDLE: begin
                if (dm_any | if_req) begin
                    mem_req_n = 1'b1;
                    last_dm_n = grant_dm;
`ifdef ARB_TIMEOUT_EN
                    cnt_n     = '0;
`endif
                    if (grant_dm) begin
                        state_n     = BUSY_DM;
                        mem_we_n    = dm_write;
                        mem_addr_n  = dm_addr;
                        mem_wdata_n = dm_wdata;
                    end else begin
                        state_n    = BUSY_IF;
                        mem_we_n   = 1'b0;
                        mem_addr_n = if_addr;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (finish) begin
                    mem_req_n = 1'b0;
                    state_n   = DONE;
                    if (state == BUSY_IF) begin
                        if_valid_n = 1'b1;
                        if_rdata_n = rdata_sel;
                    end else begin
                        dm_valid_n = 1'b1;
                        if (!mem_we)
                            dm_rdata_n = rdata_sel;
                    end
`ifdef ARB_TIMEOUT_EN
                    if (!mem_ack)
                        err_n = 1'b1;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_n = cnt + 1'b1;
`endif
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last_dm   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            last_dm   <= last_dm_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
            if_valid  <= if_valid_n;
            dm_valid  <= dm_valid_n;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb/tb_pipeline_mem_arbiter.sv - self-checking bench for pipeline_mem_arbiter with a transaction-level model.
module tb_pipeline_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_valid, if_stall;
    logic [8:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_read, dm_write, dm_valid, dm_stall;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack, arb_err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    pipeline_mem_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] slave_mem [512];
    logic [31:0] ref_mem   [512];

    // requester intent
    logic if_pend, dm_pend, d_rd, d_wr, keep, rnd;
    // memory slave
    logic        sv_active, busy_seen, no_ack, sv_we;
    logic [8:0]  sv_addr;
    logic [31:0] sv_wd;
    int          wait_left, forced_wait;
    // transaction model
    logic        m_busy, m_done, m_last_dm, m_own_dm, m_we, m_err;
    logic [8:0]  m_addr;
    logic [31:0] m_wd, m_if_rd, m_dm_rd;
    int          m_bcnt, step_no, grant_step, valid_gap, req_cycles, ifv_cnt, dmv_cnt;
    logic [8:0]  glog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void drive();
        if_req   = if_pend;
        dm_read  = dm_pend & d_rd;
        dm_write = dm_pend & d_wr;
    endfunction

    task automatic step();
        logic p_rst, p_if, p_dm, p_dwr, ack_b, fin, to, exp_ifv, exp_dmv;
        logic [8:0]  p_iaddr, p_daddr;
        logic [31:0] p_dwd;
        int k;
        drive();
        p_rst = reset; p_if = if_req; p_dm = dm_read | dm_write; p_dwr = dm_write;
        p_iaddr = if_addr; p_daddr = dm_addr; p_dwd = dm_wdata;
        ack_b = mem_ack & sv_active;
        @(posedge clk);
        #1;
        exp_ifv = 1'b0;
        exp_dmv = 1'b0;
        if (!p_rst) begin
            m_busy = 0; m_done = 0; m_last_dm = 0; m_if_rd = 0; m_dm_rd = 0; m_err = 0;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            sv_active = 0; busy_seen = 0; mem_ack = 0;
        end else if (m_done) begin
            m_done = 0;
            chk("done_mem_req", mem_req, 0);
        end else if (!m_busy) begin
            if (p_if | p_dm) begin
                m_own_dm  = p_dm && (!p_if || !m_last_dm);
                m_last_dm = m_own_dm;
                m_busy = 1; m_bcnt = 0; grant_step = step_no;
                m_we   = m_own_dm ? p_dwr : 1'b0;
                m_addr = m_own_dm ? p_daddr : p_iaddr;
                m_wd   = p_dwd;
                glog.push_back(mem_addr);
            end
            chk("idle_or_grant_mem_req", mem_req, m_busy);
        end else begin
            fin = ack_b;
            to  = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (!ack_b && m_bcnt == TO - 1) begin
                fin = 1'b1;
                to  = 1'b1;
            end
`endif
            if (fin) begin
                m_busy = 0; m_done = 1; valid_gap = step_no - grant_step;
                if (to) m_err = 1;
                if (m_own_dm) begin
                    exp_dmv = 1;
                    if (!m_we) m_dm_rd = to ? 32'h0 : ref_mem[m_addr];
                    else if (!to) ref_mem[m_addr] = m_wd;
                end else begin
                    exp_ifv = 1;
                    m_if_rd = to ? 32'h0 : ref_mem[m_addr];
                end
            end else begin
                m_bcnt++;
            end
            chk("busy_mem_req", mem_req, !fin);
        end
        if (m_busy) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_own_dm) chk("mem_wdata", mem_wdata, m_wd);
        end
        chk("if_valid", if_valid, exp_ifv);
        chk("dm_valid", dm_valid, exp_dmv);
        chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
        chk("arb_err", arb_err, m_err);
        chk("if_stall", if_stall, if_req & ~exp_ifv);
        chk("dm_stall", dm_stall, (dm_read | dm_write) & ~exp_dmv);
        if (mem_req === 1'b1) req_cycles++;
        if (if_valid === 1'b1) ifv_cnt++;
        if (dm_valid === 1'b1) dmv_cnt++;

        // memory slave: ack after a chosen number of wait cycles
        if (mem_ack && sv_active) begin
            if (sv_we) slave_mem[sv_addr] = sv_wd;
            mem_ack = 0; sv_active = 0;
        end else if (mem_ack) begin
            mem_ack = 0;
        end else if (mem_req && !no_ack) begin
            if (!busy_seen) begin
                busy_seen = 1;
                wait_left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
                mem_ack = 1; sv_active = 1; mem_rdata = slave_mem[mem_addr];
                sv_we = mem_we; sv_addr = mem_addr; sv_wd = mem_wdata;
            end else begin
                wait_left--;
            end
        end
        if (!mem_ack) mem_rdata = $urandom;
        if (!mem_req) busy_seen = 0;

        if (exp_ifv && !keep) if_pend = 0;
        if (exp_dmv && !keep) dm_pend = 0;
        if (rnd) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if_addr = 9'($urandom_range(0, 511));
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1;
                dm_addr = 9'($urandom_range(0, 15));
                dm_wdata = $urandom;
                k = int'($urandom_range(0, 7));
                d_rd = (k < 4) || (k == 7);
                d_wr = (k >= 4);
            end
        end
        drive();
        step_no++;
    endtask

    task automatic do_reset();
        reset = 0; if_pend = 0; dm_pend = 0; keep = 0; no_ack = 0; forced_wait = -1;
        step();
        step();
        reset = 1;
        step();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((m_busy || m_done || if_pend || dm_pend) && n < budget) begin
            step();
            n++;
        end
        chk(tag, (m_busy || m_done || if_pend || dm_pend), 0);
    endtask

    initial begin
        logic [31:0] v;
        int n;
        for (int i = 0; i < 512; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        slave_mem[4] = 32'h00500093;
        ref_mem[4]   = 32'h00500093;
        if_pend = 0; dm_pend = 0; d_rd = 0; d_wr = 0; keep = 0; rnd = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        mem_ack = 0; mem_rdata = 0; sv_active = 0; busy_seen = 0; no_ack = 0;
        sv_we = 0; sv_addr = 0; sv_wd = 0; wait_left = 0; forced_wait = -1;
        m_busy = 0; m_done = 0; m_last_dm = 0; m_own_dm = 0; m_we = 0; m_err = 0;
        m_addr = 0; m_wd = 0; m_if_rd = 0; m_dm_rd = 0; m_bcnt = 0;
        step_no = 0; grant_step = 0; valid_gap = 0; req_cycles = 0; ifv_cnt = 0; dmv_cnt = 0;
        drive();

        do_reset();

        // single IF read, two-cycle memory
        req_cycles = 0; ifv_cnt = 0; forced_wait = 1;
        if_addr = 9'h004; if_pend = 1;
        run_until_idle(20, "if_read_done");
        chk("if_read_req_cycles", req_cycles, 2);
        chk("if_read_valid_pulses", ifv_cnt, 1);
        chk("if_read_data", if_rdata, 32'h00500093);

        // DM store, zero-wait memory
        req_cycles = 0; dmv_cnt = 0; forced_wait = 0;
        dm_addr = 9'h010; dm_wdata = 32'hDEADBEEF; d_rd = 0; d_wr = 1; dm_pend = 1;
        run_until_idle(20, "dm_write_done");
        chk("dm_write_grant_to_valid_edges", valid_gap, 1);
        chk("dm_write_valid_pulses", dmv_cnt, 1);
        chk("dm_write_stored", slave_mem[16], 32'hDEADBEEF);

        // continuous tie: DM, IF, DM, IF
        do_reset();
        glog.delete();
        keep = 1; forced_wait = -1;
        if_addr = 9'h020; if_pend = 1;
        dm_addr = 9'h030; d_rd = 1; d_wr = 0; dm_pend = 1;
        n = 0;
        while (glog.size() < 4 && n < 60) begin
            step();
            n++;
        end
        keep = 0;
        run_until_idle(40, "tie_drain");
        chk("tie_grants", glog.size() >= 4, 1);
        if (glog.size() >= 4) begin
            chk("tie_grant0", glog[0], 9'h030);
            chk("tie_grant1", glog[1], 9'h020);
            chk("tie_grant2", glog[2], 9'h030);
            chk("tie_grant3", glog[3], 9'h020);
        end

        // reset while DM access waits for ack
        no_ack = 1;
        dm_addr = 9'h005; d_rd = 1; d_wr = 0; dm_pend = 1;
        n = 0;
        while (!m_busy && n < 10) begin
            step();
            n++;
        end
        chk("abort_granted", m_busy, 1);
        step();
        dmv_cnt = 0;
        reset = 0; dm_pend = 0;
        step();
        reset = 1; no_ack = 0;
        step();
        mem_ack = 1;
        step();
        step();
        chk("abort_no_dm_valid", dmv_cnt, 0);
        glog.delete();
        if_addr = 9'h021; if_pend = 1;
        dm_addr = 9'h031; d_rd = 0; d_wr = 1; dm_wdata = 32'h12345678; dm_pend = 1;
        run_until_idle(40, "post_reset_tie_done");
        chk("post_reset_first_grant", glog.size() > 0 ? glog[0] : 9'h1FF, 9'h031);

        // memory that never acknowledges
        req_cycles = 0; no_ack = 1;
        if_addr = 9'h007; if_pend = 1;
        for (int i = 0; i < 40; i++) step();
`ifdef ARB_TIMEOUT_EN
        chk("timeout_req_cycles", req_cycles, TO);
        chk("timeout_err_sticky", arb_err, 1);
        chk("timeout_if_rdata", if_rdata, 0);
`else
        chk("noack_req_held", mem_req, 1);
        chk("noack_req_cycles", req_cycles, 40);
        chk("noack_no_err", arb_err, 0);
`endif
        do_reset();

        // randomized traffic
        rnd = 1;
        for (int i = 0; i < 800; i++) step();
        rnd = 0;
        run_until_idle(100, "random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
